// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
// Load funct3 encodings, buffer entry layout and buffer geometry.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 64;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] rd;
        logic                 we;
    } wb_entry_t;

    // Natural alignment check for a load of the given funct3 at byte offset off.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [2:0] off);
        logic bad;
        case (funct3)
            LB, LBU: bad = 1'b0;
            LH, LHU: bad = off[0];
            LW, LWU: bad = |off[1:0];
            LD:      bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter: selects the addressed byte/half/word of an
// aligned doubleword and sign- or zero-extends it; flags misaligned or illegal loads.
module load_formatter
    import wb_pkg::*;
(
    input  logic [WB_DATA_W-1:0] mem_rdata,
    input  logic [2:0]           off,
    input  logic [2:0]           funct3,
    output logic [WB_DATA_W-1:0] data,
    output logic                 misaligned
);

    logic [WB_DATA_W-1:0] shifted;

    always_comb begin
        shifted    = mem_rdata >> {off, 3'b000};
        misaligned = load_misaligned(funct3, off);
        data       = '0;
        case (funct3)
            LB:      data = {{(WB_DATA_W-8){shifted[7]}}, shifted[7:0]};
            LBU:     data = {{(WB_DATA_W-8){1'b0}}, shifted[7:0]};
            LH:      data = {{(WB_DATA_W-16){shifted[15]}}, shifted[15:0]};
            LHU:     data = {{(WB_DATA_W-16){1'b0}}, shifted[15:0]};
            LW:      data = {{(WB_DATA_W-32){shifted[31]}}, shifted[31:0]};
            LWU:     data = {{(WB_DATA_W-32){1'b0}}, shifted[31:0]};
            LD:      data = mem_rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: 2-entry skid buffer between the memory stage and the register
// file write port, with load formatting, forwarding tap and retired-write counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic              MemtoReg,
    input  logic              RegWriteIn,
    input  logic [ADDR_W-1:0] RDIn,
    input  logic [2:0]        Funct3,
    input  logic              hold,
    output logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] RD,
    output logic              RegWrite,
    output logic              FwdValid,
    output logic              LoadMisaligned,
    output logic [CNT_W-1:0]  RetireCount
);

    wb_entry_t         entries_q [DEPTH];
    wb_entry_t         new_entry;
    wb_entry_t         head;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] rd_q;
    logic              misaligned_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic [DATA_W-1:0] fmt_data;
    logic              fmt_misaligned;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic              bad_load;

    load_formatter u_load_formatter (
        .mem_rdata  (MemReadData),
        .off        (ALUResult[2:0]),
        .funct3     (Funct3),
        .data       (fmt_data),
        .misaligned (fmt_misaligned)
    );

    assign push       = in_valid & in_ready_q;
    assign head_valid = (count_q != 2'd0);
    assign head       = entries_q[head_q];
    assign pop        = head_valid & ~hold;
    assign bad_load   = MemtoReg & fmt_misaligned;

    always_comb begin
        new_entry.data = MemtoReg ? fmt_data : ALUResult;
        new_entry.rd   = RDIn;
        // x0 writes and faulting loads still occupy a slot but never write.
        new_entry.we   = RegWriteIn & (RDIn != '0) & ~bad_load;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b1;
            wdata_q      <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            in_ready_q   <= (count_d < 2'(DEPTH));
            misaligned_q <= push & bad_load;
            if (head_valid) begin
                wdata_q <= head.data;
                rd_q    <= head.rd;
            end
            if (RegWrite) begin
                retire_cnt_q <= retire_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready       = in_ready_q;
        RegWrite       = pop & head.we;
        FwdValid       = head_valid & head.we;
        WriteData      = head_valid ? head.data : wdata_q;
        RD             = head_valid ? head.rd : rd_q;
        LoadMisaligned = misaligned_q;
        RetireCount    = retire_cnt_q;
    end

    a_count_range: assert property (@(posedge clk) disable iff (reset) count_q <= 2'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        (count_q == 2'(DEPTH)) |-> !push);
    a_write_fwd: assert property (@(posedge clk) disable iff (reset) RegWrite |-> FwdValid);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ALUResult;
    logic [63:0] MemReadData;
    logic        MemtoReg;
    logic        RegWriteIn;
    logic [4:0]  RDIn;
    logic [2:0]  Funct3;
    logic        hold;
    logic [63:0] WriteData;
    logic [4:0]  RD;
    logic        RegWrite;
    logic        FwdValid;
    logic        LoadMisaligned;
    logic [31:0] RetireCount;

    int n_vec  = 0;
    int n_miss = 0;

    writeback_stage dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALUResult      (ALUResult),
        .MemReadData    (MemReadData),
        .MemtoReg       (MemtoReg),
        .RegWriteIn     (RegWriteIn),
        .RDIn           (RDIn),
        .Funct3         (Funct3),
        .hold           (hold),
        .WriteData      (WriteData),
        .RD             (RD),
        .RegWrite       (RegWrite),
        .FwdValid       (FwdValid),
        .LoadMisaligned (LoadMisaligned),
        .RetireCount    (RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] alu, input logic [63:0] mrd, input logic m2r,
                         input logic rw, input logic [4:0] rd, input logic [2:0] f3);
        in_valid    = 1'b1;
        ALUResult   = alu;
        MemReadData = mrd;
        MemtoReg    = m2r;
        RegWriteIn  = rw;
        RDIn        = rd;
        Funct3      = f3;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Load table against one doubleword.
    localparam logic [63:0] LDW = 64'h1122_3344_8899_AABB;
    logic [2:0]  t_f3  [9];
    logic [2:0]  t_off [9];
    logic [63:0] t_exp [9];
    logic        t_mis [9];

    initial begin
        t_f3[0] = 3'b001; t_off[0] = 3'd2; t_exp[0] = 64'hFFFF_FFFF_FFFF_8899; t_mis[0] = 1'b0;
        t_f3[1] = 3'b101; t_off[1] = 3'd6; t_exp[1] = 64'h0000_0000_0000_1122; t_mis[1] = 1'b0;
        t_f3[2] = 3'b010; t_off[2] = 3'd0; t_exp[2] = 64'hFFFF_FFFF_8899_AABB; t_mis[2] = 1'b0;
        t_f3[3] = 3'b110; t_off[3] = 3'd4; t_exp[3] = 64'h0000_0000_1122_3344; t_mis[3] = 1'b0;
        t_f3[4] = 3'b011; t_off[4] = 3'd0; t_exp[4] = 64'h1122_3344_8899_AABB; t_mis[4] = 1'b0;
        t_f3[5] = 3'b010; t_off[5] = 3'd4; t_exp[5] = 64'h0000_0000_1122_3344; t_mis[5] = 1'b0;
        t_f3[6] = 3'b111; t_off[6] = 3'd0; t_exp[6] = 64'h0;                   t_mis[6] = 1'b1;
        t_f3[7] = 3'b011; t_off[7] = 3'd4; t_exp[7] = 64'h0;                   t_mis[7] = 1'b1;
        t_f3[8] = 3'b101; t_off[8] = 3'd3; t_exp[8] = 64'h0;                   t_mis[8] = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        hold        = 1'b0;
        in_valid    = 1'b0;
        ALUResult   = '0;
        MemReadData = '0;
        MemtoReg    = 1'b0;
        RegWriteIn  = 1'b0;
        RDIn        = '0;
        Funct3      = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_fwdvalid", 64'(FwdValid), 64'd0);
        check("rst_wdata", WriteData, 64'd0);
        check("rst_rd", 64'(RD), 64'd0);
        check("rst_misalign", 64'(LoadMisaligned), 64'd0);
        check("rst_count", 64'(RetireCount), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU result writeback
        drive(64'h2A, 64'h0, 1'b0, 1'b1, 5'd5, 3'b000);
        step();
        idle();
        check("alu_regwrite", 64'(RegWrite), 64'd1);
        check("alu_rd", 64'(RD), 64'd5);
        check("alu_wdata", WriteData, 64'h2A);
        check("alu_fwd", 64'(FwdValid), 64'd1);
        step();
        check("alu_done", 64'(RegWrite), 64'd0);
        check("alu_count", 64'(RetireCount), 64'd1);
        check("alu_wdata_held", WriteData, 64'h2A);

        // LB / LBU on byte 2 = 0x80
        drive(64'h2, 64'h0000_0000_0080_0000, 1'b1, 1'b1, 5'd6, 3'b000);
        step();
        idle();
        check("lb_wdata", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_regwrite", 64'(RegWrite), 64'd1);
        step();
        drive(64'h2, 64'h0000_0000_0080_0000, 1'b1, 1'b1, 5'd6, 3'b100);
        step();
        idle();
        check("lbu_wdata", WriteData, 64'h80);
        step();
        check("lbu_count", 64'(RetireCount), 64'd3);

        // Misaligned LW, off=1
        drive(64'h1, 64'hDEAD_BEEF_0000_0000, 1'b1, 1'b1, 5'd7, 3'b010);
        step();
        idle();
        check("mis_pulse", 64'(LoadMisaligned), 64'd1);
        check("mis_regwrite", 64'(RegWrite), 64'd0);
        check("mis_fwd", 64'(FwdValid), 64'd0);
        step();
        check("mis_pulse_end", 64'(LoadMisaligned), 64'd0);
        check("mis_regwrite2", 64'(RegWrite), 64'd0);
        check("mis_count", 64'(RetireCount), 64'd3);

        // x0 destination
        drive(64'h55, 64'h0, 1'b0, 1'b1, 5'd0, 3'b000);
        step();
        idle();
        check("x0_regwrite", 64'(RegWrite), 64'd0);
        check("x0_fwd", 64'(FwdValid), 64'd0);
        step();
        check("x0_count", 64'(RetireCount), 64'd3);

        // Load format table
        for (int i = 0; i < 9; i++) begin
            drive({61'h0, t_off[i]}, LDW, 1'b1, 1'b1, 5'(8 + i), t_f3[i]);
            step();
            idle();
            check($sformatf("ld%0d_mis", i), 64'(LoadMisaligned), 64'(t_mis[i]));
            check($sformatf("ld%0d_we", i), 64'(RegWrite), 64'(!t_mis[i]));
            if (!t_mis[i]) begin
                check($sformatf("ld%0d_wdata", i), WriteData, t_exp[i]);
            end
            step();
        end
        check("ld_count", 64'(RetireCount), 64'd9);

        // hold: three back-to-back pushes, only two accepted
        hold = 1'b1;
        drive(64'hA, 64'h0, 1'b0, 1'b1, 5'd10, 3'b000);
        step();
        check("hold_regwrite", 64'(RegWrite), 64'd0);
        check("hold_fwd", 64'(FwdValid), 64'd1);
        check("hold_ready1", 64'(in_ready), 64'd1);
        drive(64'hB, 64'h0, 1'b0, 1'b1, 5'd11, 3'b000);
        step();
        check("hold_ready2", 64'(in_ready), 64'd0);
        drive(64'hC, 64'h0, 1'b0, 1'b1, 5'd12, 3'b000);
        step();
        check("hold_ready3", 64'(in_ready), 64'd0);
        check("hold_regwrite3", 64'(RegWrite), 64'd0);
        idle();
        hold = 1'b0;
        #1;
        check("rel1_regwrite", 64'(RegWrite), 64'd1);
        check("rel1_rd", 64'(RD), 64'd10);
        check("rel1_wdata", WriteData, 64'hA);
        step();
        check("rel2_regwrite", 64'(RegWrite), 64'd1);
        check("rel2_rd", 64'(RD), 64'd11);
        check("rel2_wdata", WriteData, 64'hB);
        check("rel2_ready", 64'(in_ready), 64'd1);
        step();
        check("rel3_regwrite", 64'(RegWrite), 64'd0);
        check("rel3_rd_held", 64'(RD), 64'd11);
        check("rel_count", 64'(RetireCount), 64'd11);

        // reset with two buffered entries
        hold = 1'b1;
        drive(64'hD, 64'h0, 1'b0, 1'b1, 5'd13, 3'b000);
        step();
        drive(64'hE, 64'h0, 1'b0, 1'b1, 5'd14, 3'b000);
        step();
        idle();
        check("pre_rst_ready", 64'(in_ready), 64'd0);
        hold  = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_regwrite", 64'(RegWrite), 64'd0);
        check("mid_rst_fwd", 64'(FwdValid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_count", 64'(RetireCount), 64'd0);
        check("mid_rst_wdata", WriteData, 64'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_regwrite", 64'(RegWrite), 64'd0);
        step();
        check("post_rst_regwrite2", 64'(RegWrite), 64'd0);
        check("post_rst_count", 64'(RetireCount), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
